// File: rtl/pcie_recep.sv
// pcie_recep: receive end of the two-lane transmit path.
// Buffers lanes D0/D1 in small FIFOs, raises per-lane pause when a buffer
// reaches a programmable threshold, merges both lanes round-robin into one
// registered output stream, and tracks status with an INIT/IDLE/ACTIVE/ERROR FSM.
// Optional build macro: RECEP_STATS_EN adds per-lane output word counters
// (cnt_d0, cnt_d1).
module pcie_recep #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2,
    parameter int UMBRAL_DEF = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_W:0]       umbral_in,
    input  logic                  valid_d0,
    input  logic [DATA_WIDTH-1:0] data_d0,
    input  logic                  valid_d1,
    input  logic [DATA_WIDTH-1:0] data_d1,
    input  logic                  ready_out,
    output logic                  pausa_d0,
    output logic                  pausa_d1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  out_lane,
    output logic                  idle_out,
    output logic                  active_out,
    output logic                  error_out,
    output logic [1:0]            error_id
`ifdef RECEP_STATS_EN
    ,
    output logic [7:0]            cnt_d0,
    output logic [7:0]            cnt_d1
`endif
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W+1:0] DEPTH_W  = (ADDR_W+2)'(DEPTH);

    state_t                  state_q;
    logic [ADDR_W:0]         umbral_q;
    logic                    last_q;

    // Per-lane FIFO storage and bookkeeping, index 0 = D0, 1 = D1.
    logic [DATA_WIDTH-1:0]   mem_q    [2][DEPTH];
    logic [ADDR_W-1:0]       wr_ptr_q [2];
    logic [ADDR_W-1:0]       rd_ptr_q [2];
    logic [ADDR_W:0]         count_q  [2];
    logic [ADDR_W-1:0]       wr_ptr_d [2];
    logic [ADDR_W-1:0]       rd_ptr_d [2];
    logic [ADDR_W:0]         count_d  [2];

    logic [DATA_WIDTH-1:0]   data_in_s [2];
    logic [1:0]              valid_in_s;
    logic [1:0]              nonempty_s;
    logic [1:0]              full_s;
    logic [1:0]              tent_pop_s;
    logic [1:0]              err_s;
    logic                    run_s;
    logic                    op_ok_s;
    logic [1:0]              push_s;
    logic [1:0]              pop_s;
    logic                    pop_lane_s;
    logic [DATA_WIDTH-1:0]   pop_word_s;
    logic [ADDR_W+1:0]       level0_s;
    logic [ADDR_W+1:0]       level1_s;

    assign data_in_s[0] = data_d0;
    assign data_in_s[1] = data_d1;
    assign valid_in_s   = {valid_d1, valid_d0};
    assign run_s        = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

    // Lane occupancy flags from the registered counts.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            nonempty_s[l] = (count_q[l] != {(ADDR_W+1){1'b0}});
            full_s[l]     = (count_q[l] == FULL_CNT);
        end
    end

    // Round-robin choice: a lone non-empty lane wins, otherwise the lane not served last.
    always_comb begin
        tent_pop_s = 2'b00;
        if ((state_q == ST_ACTIVE) && ready_out && !init) begin
            if (nonempty_s == 2'b11) begin
                tent_pop_s = last_q ? 2'b01 : 2'b10;
            end else begin
                tent_pop_s = nonempty_s;
            end
        end else begin
            tent_pop_s = 2'b00;
        end
    end

    // Overflow detection and final push/pop enables; an overflow cycle freezes both lanes.
    always_comb begin
        err_s = 2'b00;
        if (run_s) begin
            err_s = valid_in_s & full_s & ~tent_pop_s;
        end else begin
            err_s = 2'b00;
        end
        op_ok_s = run_s && (err_s == 2'b00) && !init;
        if (op_ok_s) begin
            push_s = valid_in_s;
            pop_s  = tent_pop_s;
        end else begin
            push_s = 2'b00;
            pop_s  = 2'b00;
        end
    end

    // Word leaving the selected lane this cycle.
    always_comb begin
        pop_lane_s = pop_s[1];
        if (pop_lane_s) begin
            pop_word_s = mem_q[1][rd_ptr_q[1]];
        end else begin
            pop_word_s = mem_q[0][rd_ptr_q[0]];
        end
    end

    // Next pointers and counts; INIT keeps both lanes flushed.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            if (state_q == ST_INIT) begin
                wr_ptr_d[l] = {ADDR_W{1'b0}};
                rd_ptr_d[l] = {ADDR_W{1'b0}};
                count_d[l]  = {(ADDR_W+1){1'b0}};
            end else begin
                wr_ptr_d[l] = wr_ptr_q[l] + ADDR_W'(push_s[l]);
                rd_ptr_d[l] = rd_ptr_q[l] + ADDR_W'(pop_s[l]);
                case ({push_s[l], pop_s[l]})
                    2'b10:   count_d[l] = count_q[l] + (ADDR_W+1)'(1);
                    2'b01:   count_d[l] = count_q[l] - (ADDR_W+1)'(1);
                    default: count_d[l] = count_q[l];
                endcase
            end
        end
    end

    // FIFO pointer/count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= {ADDR_W{1'b0}};
                rd_ptr_q[l] <= {ADDR_W{1'b0}};
                count_q[l]  <= {(ADDR_W+1){1'b0}};
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= wr_ptr_d[l];
                rd_ptr_q[l] <= rd_ptr_d[l];
                count_q[l]  <= count_d[l];
            end
        end
    end

    // FIFO storage writes; the read side sees the old word on a same-slot push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[l][e] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push_s[l]) begin
                    mem_q[l][wr_ptr_q[l]] <= data_in_s[l];
                end
            end
        end
    end

    // Registered merged output; data_out and out_lane hold when nothing is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= {DATA_WIDTH{1'b0}};
            out_lane  <= 1'b0;
            last_q    <= 1'b1;
        end else if (pop_s != 2'b00) begin
            valid_out <= 1'b1;
            data_out  <= pop_word_s;
            out_lane  <= pop_lane_s;
            last_q    <= pop_lane_s;
        end else begin
            valid_out <= 1'b0;
        end
    end

    // Control FSM: threshold latch in INIT, sticky overflow flags, error beats init.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            umbral_q <= (ADDR_W+1)'(UMBRAL_DEF);
            error_id <= 2'b00;
        end else begin
            case (state_q)
                ST_INIT: begin
                    umbral_q <= umbral_in;
                    if (!init) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (err_s != 2'b00) begin
                        state_q  <= ST_ERROR;
                        error_id <= error_id | err_s;
                    end else if (init) begin
                        state_q <= ST_INIT;
                    end else if (valid_in_s != 2'b00) begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (err_s != 2'b00) begin
                        state_q  <= ST_ERROR;
                        error_id <= error_id | err_s;
                    end else if (init) begin
                        state_q <= ST_INIT;
                    end else if ((nonempty_s == 2'b00) && (push_s == 2'b00) && !valid_out) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign idle_out   = (state_q == ST_IDLE);
    assign active_out = (state_q == ST_ACTIVE);
    assign error_out  = (state_q == ST_ERROR);

    // Pause when count >= DEPTH - umbral, written as a sum to avoid underflow.
    always_comb begin
        level0_s = {1'b0, count_q[0]} + {1'b0, umbral_q};
        level1_s = {1'b0, count_q[1]} + {1'b0, umbral_q};
        pausa_d0 = (level0_s >= DEPTH_W);
        pausa_d1 = (level1_s >= DEPTH_W);
    end

`ifdef RECEP_STATS_EN
    // Per-lane count of emitted words, wrapping, cleared in INIT.
    always_ff @(posedge clk) begin
        if (reset || (state_q == ST_INIT)) begin
            cnt_d0 <= 8'd0;
            cnt_d1 <= 8'd0;
        end else if (valid_out) begin
            if (out_lane) begin
                cnt_d1 <= cnt_d1 + 8'd1;
            end else begin
                cnt_d0 <= cnt_d0 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pcie_recep.md
Name: pcie_recep

Overview:
Receive end of the PCIe-style transmit path. Accepts 6-bit words from the two destination lanes, D0 and D1, and buffers each lane in a small FIFO. Drives per-lane pause (back-pressure) to the upstream D0/D1 FIFOs when its own buffers pass a programmable threshold. Merges both lanes round-robin into one registered output stream and reports status through an INIT/IDLE/ACTIVE/ERROR control FSM.

Parameters:
DATA_WIDTH, 6, word width (bit 4 carries destination, bits 5:4 carry vc/dest tags; passed through untouched)
DEPTH, 4, entries per lane FIFO (power of 2)
ADDR_W, 2, log2(DEPTH)
UMBRAL_DEF, 1, reset value of the almost-full threshold

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous reset, active-high
init  in  1  forces INIT state; threshold programming window
umbral_in  in  ADDR_W+1  almost-full threshold; latched only while in INIT
valid_d0  in  1  word present on data_d0
data_d0  in  DATA_WIDTH  lane D0 word
valid_d1  in  1  word present on data_d1
data_d1  in  DATA_WIDTH  lane D1 word
ready_out  in  1  sink accepts a word this cycle
pausa_d0  out  1  lane D0 buffer almost full
pausa_d1  out  1  lane D1 buffer almost full
data_out  out  DATA_WIDTH  merged output word (registered)
valid_out  out  1  data_out valid (registered)
out_lane  out  1  source lane of data_out (0=D0, 1=D1)
idle_out  out  1  high only in IDLE
active_out  out  1  high only in ACTIVE
error_out  out  1  high only in ERROR
error_id  out  2  sticky overflow flags; bit0=D0, bit1=D1

Behaviour:
- Reset (reset=1 at clk edge):
  - All outputs 0; state=INIT; umbral=UMBRAL_DEF.
  - FIFO pointers and counts 0.
  - Round-robin last-served=1, so D0 wins the first tie.
- Lane FIFOs:
  - Count width ADDR_W+1; pointers wrap modulo DEPTH.
  - Push when valid_dX and state is IDLE or ACTIVE.
  - Pop only as selected by the arbiter.
  - Push and pop on the same lane in the same cycle: count unchanged, also when the lane is full.
- pausa_dX = (count_X >= DEPTH - umbral), evaluated from registered counts:
  - umbral=0 asserts only when full.
  - umbral>=DEPTH asserts permanently.
- Arbiter/output, state ACTIVE only:
  - Fires when ready_out=1 and at least one lane is non-empty.
  - One non-empty lane: that lane is popped.
  - Both non-empty: the lane not last served is popped, then last-served updates.
  - The popped word appears on data_out, with valid_out=1 and out_lane set, at the next edge (latency 1).
  - Otherwise valid_out=0 next cycle; data_out holds its last value.
  - Never pops an empty lane.
- FSM:
  - INIT:
    - umbral<=umbral_in every cycle.
    - FIFOs held flushed; valid_dX ignored; valid_out=0.
    - Exit to IDLE when init=0.
  - IDLE:
    - To INIT if init=1; init has priority over every other transition except error.
    - To ACTIVE when valid_d0 or valid_d1 is seen; that word is stored in the same cycle.
  - ACTIVE:
    - To INIT if init=1.
    - To IDLE when both FIFOs are empty, no push this cycle and valid_out=0.
  - ERROR:
    - Entered from IDLE/ACTIVE when valid_dX=1, lane X is full and lane X is not popped that cycle; error_id[X]<=1.
    - Both lanes may set their flags in the same cycle.
    - The offending word is dropped.
    - Sticky: all pushes and pops disabled, valid_out=0, init ignored; exit only through reset.
- Reset applied mid-transfer discards buffered data; no output is emitted on the following cycle.

Optional Feature:
RECEP_STATS_EN
- Defined:
  - Adds outputs cnt_d0 and cnt_d1 (8 bits each).
  - cnt_X increments each cycle valid_out=1 with out_lane=X, wrapping 255->0.
  - Cleared by reset and while in INIT.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then init=1 with umbral_in=2 for 2 cycles, then init=0 -> idle_out=1 in the cycle after init drops; pausa_d0=pausa_d1=0.
- IDLE with ready_out=1; one D0 word 6'h05 -> active_out=1 next cycle; data_out=6'h05, valid_out=1, out_lane=0 two cycles after push; back to IDLE once drained.
- ready_out=0; push D0 6'h01,6'h02 and D1 6'h11,6'h12; then ready_out=1 -> output order 01,11,02,12 on consecutive cycles.
- umbral=1, ready_out=0; push 3 words on D1 -> pausa_d1=1 after the 3rd push; D0 unaffected.
- ready_out=0; fill D0 (4 words), push a 5th -> error_out=1, error_id=2'b01; later init=1 has no effect; only reset returns to INIT with all outputs 0.
- D0 full, ready_out=1, D0 selected, push in the same cycle -> no error; count stays 4.
